// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one MFA/MFC memory handshake between instruction fetch (port 0)
// and data load/store (port 1), with round-robin fairness and an MFC timeout abort.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [AW-1:0] ADD0,
  input  logic [AW-1:0] ADD1,
  input  logic          RW0,
  input  logic          RW1,
  input  logic          WB0,
  input  logic          WB1,
  input  logic [DW-1:0] WDAT0,
  input  logic [DW-1:0] WDAT1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          ERR,
  output logic [DW-1:0] RDAT,
  output logic          MFA,
  output logic [AW-1:0] MEMADD,
  output logic          READ_WRITE,
  output logic          WORD_BYTE,
  output logic [DW-1:0] MEMDAT_OUT,
  input  logic          MFC,
  input  logic [DW-1:0] MEMDAT
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_grant;
  logic          owner;
  logic          winner;
  logic          grant_ok;
  logic          owner_req;

  // A grant waits until the memory has released MFC from the previous cycle.
  always_comb begin
    grant_ok  = (REQ0 | REQ1) & ~MFC;
    winner    = (REQ0 & REQ1) ? ~last_grant : REQ1;
    owner_req = owner ? REQ1 : REQ0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      ERR        <= 1'b0;
      RDAT       <= '0;
      MFA        <= 1'b0;
      MEMADD     <= '0;
      READ_WRITE <= 1'b1;
      WORD_BYTE  <= 1'b1;
      MEMDAT_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            owner      <= winner;
            last_grant <= winner;
            MEMADD     <= winner ? ADD1  : ADD0;
            READ_WRITE <= winner ? RW1   : RW0;
            WORD_BYTE  <= winner ? WB1   : WB0;
            MEMDAT_OUT <= winner ? WDAT1 : WDAT0;
            MFA        <= 1'b1;
            timer      <= '0;
            state      <= ACCESS;
          end
        end
        // MFC is checked before the timer so a completion on the expiry cycle is not an error.
        ACCESS: begin
          if (MFC) begin
            MFA   <= 1'b0;
            ERR   <= 1'b0;
            ACK0  <= ~owner;
            ACK1  <= owner;
            state <= DONE;
            if (READ_WRITE) begin
              RDAT <= MEMDAT;
            end
          end else if (timer == TIMER_LAST) begin
            MFA   <= 1'b0;
            ERR   <= 1'b1;
            ACK0  <= ~owner;
            ACK1  <= owner;
            state <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          if (!owner_req && !MFC) begin
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            ERR   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
